control_sequencer: RTL and testbench

- Consumes the 4-bit opcode from the instruction register and drives every bus-control strobe for the 8-bit SAP datapath, including the IR's own load and drive enables.
- Runs a fixed T-state ring: fetch in T0–T1, opcode-dependent execute in T2..T(NUM_STEPS-1).
- Control outputs are combinational from the registered step counter and the opcode input.
- A registered halted state stops the machine until reset.

---
 rtl/ctrl_pkg.sv | 56 +++++
 rtl/ctrl_step_counter.sv | 38 +++
 rtl/control_sequencer.sv | 133 +++++++++++++
 tb/tb_control_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, T-state constants and control-word bit indices for the SAP sequencer
package ctrl_pkg;

  // Instruction opcodes (instruction[7:4])
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // T-state numbers; steps beyond T4 never carry strobes
  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int T4 = 4;

  // Bit positions of each strobe inside a packed control word
  typedef enum logic [3:0] {
    CW_PC_INC  = 4'd0,
    CW_PC_OUT  = 4'd1,
    CW_PC_IN   = 4'd2,
    CW_MAR_IN  = 4'd3,
    CW_RAM_OUT = 4'd4,
    CW_RAM_IN  = 4'd5,
    CW_IR_IN   = 4'd6,
    CW_IR_OUT  = 4'd7,
    CW_A_IN    = 4'd8,
    CW_A_OUT   = 4'd9,
    CW_B_IN    = 4'd10,
    CW_ALU_OUT = 4'd11,
    CW_SUB     = 4'd12,
    CW_OUT_IN  = 4'd13
  } cw_bit_e;

  localparam int CW_W = 14;

  typedef logic [CW_W-1:0] ctrl_word_t;

  // Run/halt state of the machine
  typedef enum logic {
    RUN_S  = 1'b0,
    HALT_S = 1'b1
  } run_state_e;

  // One-hot control word with a single strobe set
  function automatic ctrl_word_t cw_bit(input cw_bit_e b);
    return ctrl_word_t'(1) << b;
  endfunction

endpackage

// File: rtl/ctrl_step_counter.sv
// rtl/ctrl_step_counter.sv - T-state ring counter with wrap, freeze and synchronous reset
module ctrl_step_counter #(
  parameter int NUM_STEPS = 5,
  parameter int STEP_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze_i,
  output logic [STEP_W-1:0] step_o
);

  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_d;

  // Next step: hold when frozen, wrap after the last T-state, else advance
  always_comb begin
    step_d = step_q;
    if (!freeze_i) begin
      if (step_q == STEP_W'(NUM_STEPS - 1)) begin
        step_d = '0;
      end else begin
        step_d = step_q + STEP_W'(1);
      end
    end
  end

  // Step register; reset overrides freeze
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step_o = step_q;

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - SAP microcode sequencer; conditional jumps JC/JZ enabled by CTRL_FLAG_JUMP_EN
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int NUM_STEPS = 5,
  parameter int STEP_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        opcode,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic              pc_inc,
  output logic              pc_out,
  output logic              pc_in,
  output logic              mar_in,
  output logic              ram_out,
  output logic              ram_in,
  output logic              ir_in,
  output logic              ir_out,
  output logic              a_in,
  output logic              a_out,
  output logic              b_in,
  output logic              alu_out,
  output logic              sub,
  output logic              out_in,
  output logic              halt,
  output logic [STEP_W-1:0] step
);

  run_state_e        state_q;
  logic [STEP_W-1:0] step_w;
  logic              hlt_at_t2;
  logic              freeze;
  ctrl_word_t        ctrl_w;

  assign hlt_at_t2 = (state_q == RUN_S) && (step_w == STEP_W'(T2)) && (opcode == OP_HLT);
  // The HLT edge itself must not advance the ring, so step stays at T2
  assign freeze    = (state_q == HALT_S) || hlt_at_t2;

  ctrl_step_counter #(
    .NUM_STEPS (NUM_STEPS),
    .STEP_W    (STEP_W)
  ) u_step (
    .clk      (clk),
    .rst      (rst),
    .freeze_i (freeze),
    .step_o   (step_w)
  );

  // Run/halt state machine; only reset leaves HALT_S
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN_S;
    end else begin
      case (state_q)
        RUN_S:   if (hlt_at_t2) state_q <= HALT_S;
        HALT_S:  state_q <= HALT_S;
        default: state_q <= RUN_S;
      endcase
    end
  end

`ifdef CTRL_FLAG_JUMP_EN
  logic jc_taken;
  logic jz_taken;
  assign jc_taken = flag_c;
  assign jz_taken = flag_z;
`else
  logic unused_flags;
  assign unused_flags = flag_c ^ flag_z;
`endif

  // Microcode decode from the current T-state and opcode; reset and halt blank everything
  always_comb begin
    ctrl_w = '0;
    if (!rst && (state_q == RUN_S)) begin
      case (step_w)
        STEP_W'(T0): ctrl_w = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_IN);
        STEP_W'(T1): ctrl_w = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_IN) | cw_bit(CW_PC_INC);
        STEP_W'(T2): begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA:
                    ctrl_w = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_IN);
            OP_LDI: ctrl_w = cw_bit(CW_IR_OUT) | cw_bit(CW_A_IN);
            OP_JMP: ctrl_w = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_IN);
            OP_OUT: ctrl_w = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_IN);
`ifdef CTRL_FLAG_JUMP_EN
            OP_JC:  if (jc_taken) ctrl_w = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_IN);
            OP_JZ:  if (jz_taken) ctrl_w = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_IN);
`endif
            default: ctrl_w = '0;
          endcase
        end
        STEP_W'(T3): begin
          case (opcode)
            OP_LDA:  ctrl_w = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_IN);
            OP_ADD:  ctrl_w = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_IN);
            OP_SUB:  ctrl_w = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_IN) | cw_bit(CW_SUB);
            OP_STA:  ctrl_w = cw_bit(CW_A_OUT) | cw_bit(CW_RAM_IN);
            default: ctrl_w = '0;
          endcase
        end
        STEP_W'(T4): begin
          case (opcode)
            OP_ADD:  ctrl_w = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_IN);
            OP_SUB:  ctrl_w = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_IN) | cw_bit(CW_SUB);
            default: ctrl_w = '0;
          endcase
        end
        default: ctrl_w = '0;
      endcase
    end
  end

  assign pc_inc  = ctrl_w[CW_PC_INC];
  assign pc_out  = ctrl_w[CW_PC_OUT];
  assign pc_in   = ctrl_w[CW_PC_IN];
  assign mar_in  = ctrl_w[CW_MAR_IN];
  assign ram_out = ctrl_w[CW_RAM_OUT];
  assign ram_in  = ctrl_w[CW_RAM_IN];
  assign ir_in   = ctrl_w[CW_IR_IN];
  assign ir_out  = ctrl_w[CW_IR_OUT];
  assign a_in    = ctrl_w[CW_A_IN];
  assign a_out   = ctrl_w[CW_A_OUT];
  assign b_in    = ctrl_w[CW_B_IN];
  assign alu_out = ctrl_w[CW_ALU_OUT];
  assign sub     = ctrl_w[CW_SUB];
  assign out_in  = ctrl_w[CW_OUT_IN];
  assign halt    = (state_q == HALT_S);
  assign step    = step_w;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized and directed checks of control_sequencer against a table model
module tb_control_sequencer;
  import ctrl_pkg::*;

  localparam int NUM_STEPS = 5;
  localparam int STEP_W    = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [3:0]        opcode = 4'h0;
  logic              flag_c = 1'b0;
  logic              flag_z = 1'b0;
  logic              pc_inc, pc_out, pc_in, mar_in, ram_out, ram_in, ir_in, ir_out;
  logic              a_in, a_out, b_in, alu_out, sub, out_in, halt;
  logic [STEP_W-1:0] step;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  control_sequencer #(.NUM_STEPS(NUM_STEPS), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
    .pc_inc(pc_inc), .pc_out(pc_out), .pc_in(pc_in), .mar_in(mar_in),
    .ram_out(ram_out), .ram_in(ram_in), .ir_in(ir_in), .ir_out(ir_out),
    .a_in(a_in), .a_out(a_out), .b_in(b_in), .alu_out(alu_out), .sub(sub),
    .out_in(out_in), .halt(halt), .step(step)
  );

  ctrl_word_t obs_cw;
  always_comb begin
    obs_cw = '0;
    obs_cw[CW_PC_INC]  = pc_inc;
    obs_cw[CW_PC_OUT]  = pc_out;
    obs_cw[CW_PC_IN]   = pc_in;
    obs_cw[CW_MAR_IN]  = mar_in;
    obs_cw[CW_RAM_OUT] = ram_out;
    obs_cw[CW_RAM_IN]  = ram_in;
    obs_cw[CW_IR_IN]   = ir_in;
    obs_cw[CW_IR_OUT]  = ir_out;
    obs_cw[CW_A_IN]    = a_in;
    obs_cw[CW_A_OUT]   = a_out;
    obs_cw[CW_B_IN]    = b_in;
    obs_cw[CW_ALU_OUT] = alu_out;
    obs_cw[CW_SUB]     = sub;
    obs_cw[CW_OUT_IN]  = out_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: microcode table indexed by opcode and T-state, plus abstract step/halt state
  ctrl_word_t ucode [16][5];
  ctrl_word_t fetch [2];
  int m_step  = 0;
  bit m_halt  = 1'b0;
  bit m_known = 1'b0;

  function automatic ctrl_word_t bm(input int b);
    ctrl_word_t v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  task automatic build_table();
    for (int o = 0; o < 16; o++)
      for (int s = 0; s < 5; s++)
        ucode[o][s] = '0;
    fetch[0] = bm(CW_PC_OUT) | bm(CW_MAR_IN);
    fetch[1] = bm(CW_RAM_OUT) | bm(CW_IR_IN) | bm(CW_PC_INC);
    ucode[0][2]  = bm(CW_IR_OUT) | bm(CW_MAR_IN);
    ucode[0][3]  = bm(CW_RAM_OUT) | bm(CW_A_IN);
    ucode[1][2]  = bm(CW_IR_OUT) | bm(CW_MAR_IN);
    ucode[1][3]  = bm(CW_RAM_OUT) | bm(CW_B_IN);
    ucode[1][4]  = bm(CW_ALU_OUT) | bm(CW_A_IN);
    ucode[2][2]  = ucode[1][2];
    ucode[2][3]  = ucode[1][3] | bm(CW_SUB);
    ucode[2][4]  = ucode[1][4] | bm(CW_SUB);
    ucode[4][2]  = bm(CW_IR_OUT) | bm(CW_MAR_IN);
    ucode[4][3]  = bm(CW_A_OUT) | bm(CW_RAM_IN);
    ucode[5][2]  = bm(CW_IR_OUT) | bm(CW_A_IN);
    ucode[6][2]  = bm(CW_IR_OUT) | bm(CW_PC_IN);
    ucode[14][2] = bm(CW_A_OUT) | bm(CW_OUT_IN);
  endtask

  function automatic ctrl_word_t model_cw(input int st, input logic [3:0] op,
                                          input bit fc, input bit fz, input bit r, input bit h);
    if (r || h) return '0;
    if (st < 2) return fetch[st];
    if (st > 4) return '0;
`ifdef CTRL_FLAG_JUMP_EN
    if (st == 2 && op == 4'd7) return fc ? (bm(CW_IR_OUT) | bm(CW_PC_IN)) : '0;
    if (st == 2 && op == 4'd8) return fz ? (bm(CW_IR_OUT) | bm(CW_PC_IN)) : '0;
`endif
    return ucode[op][st];
  endfunction

  // One clock cycle: drive at negedge, check settled outputs, advance model at posedge
  task automatic cyc(input bit r, input logic [3:0] op, input bit fc, input bit fz);
    ctrl_word_t drv;
    @(negedge clk);
    rst = r; opcode = op; flag_c = fc; flag_z = fz;
    #1;
    drv = obs_cw & (bm(CW_PC_OUT) | bm(CW_RAM_OUT) | bm(CW_IR_OUT) | bm(CW_A_OUT) | bm(CW_ALU_OUT));
    check("strobes", 32'(obs_cw), 32'(model_cw(m_step, op, fc, fz, r, m_halt)));
    check("bus_onehot", 32'($countones(drv) <= 1), 32'd1);
    if (m_known) begin
      check("step", 32'(step), 32'(m_step));
      check("halt", 32'(halt), 32'(m_halt));
      check("step_range", 32'(int'(step) <= NUM_STEPS - 1), 32'd1);
    end
    @(posedge clk);
    if (r) begin
      m_step = 0; m_halt = 1'b0; m_known = 1'b1;
    end else if (m_known && !m_halt) begin
      if (m_step == 2 && op == 4'hF) m_halt = 1'b1;
      else m_step = (m_step + 1) % NUM_STEPS;
    end
  endtask

  initial begin
    build_table();
    // Reset for two cycles
    cyc(1, 4'h3, 0, 0);
    cyc(1, 4'h3, 0, 0);
    // ADD then SUB instructions
    repeat (NUM_STEPS) cyc(0, OP_ADD, 0, 0);
    repeat (NUM_STEPS) cyc(0, OP_SUB, 0, 0);
    // LDA interrupted by reset in T3
    repeat (3) cyc(0, OP_LDA, 0, 0);
    cyc(1, OP_LDA, 0, 0);
    repeat (NUM_STEPS) cyc(0, OP_LDA, 0, 0);
    // Remaining opcodes once each
    repeat (NUM_STEPS) cyc(0, OP_STA, 0, 0);
    repeat (NUM_STEPS) cyc(0, OP_LDI, 0, 0);
    repeat (NUM_STEPS) cyc(0, OP_JMP, 0, 0);
    repeat (NUM_STEPS) cyc(0, OP_OUT, 0, 0);
    repeat (NUM_STEPS) cyc(0, 4'h3, 0, 0);
    // Conditional jumps with both flag values
    for (int f = 0; f < 2; f++) begin
      repeat (NUM_STEPS) cyc(0, OP_JC, f[0], ~f[0]);
      repeat (NUM_STEPS) cyc(0, OP_JZ, ~f[0], f[0]);
    end
    // HLT, stay halted 10 cycles, then single-cycle reset
    repeat (3) cyc(0, OP_HLT, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 4'($urandom_range(0, 15)), 1, 1);
    cyc(1, OP_HLT, 0, 0);
    repeat (NUM_STEPS) cyc(0, OP_LDI, 0, 0);
    // Random opcodes, flags and occasional reset
    for (int i = 0; i < 1000; i++)
      cyc($urandom_range(0, 39) == 0, 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
